// File: rtl/network_stream_source_pkg.sv
// Shared opcode/state definitions for the network stream source.
// Data widths are deliberately absent; they derive from module parameters.
package source_config;

   localparam int unsigned OPC_WIDTH = 2;

   typedef enum logic [OPC_WIDTH-1:0] {
      OpNom = 2'd0,
      OpClr = 2'd1,
      OpRun = 2'd2,
      OpSpk = 2'd3
   } opcode_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StRun,
      StClear
   } state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous power-of-two command FIFO; push is ignored when full, pop when empty.
module stream_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic             push_en;
   logic             pop_en;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count    <= '0;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/network_stream_source.sv
// Decodes queued commands into network input vectors, sparse charges, zero runs
// and clear pulses, handing vectors to the network with a valid/ready handshake.
module network_stream_source
   import source_config::*;
#(
   parameter int unsigned NUM_INP      = 4,
   parameter int unsigned CHARGE_WIDTH = 8,
   parameter int unsigned RUN_WIDTH    = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   localparam int unsigned IDX_WIDTH   = (NUM_INP > 1) ? $clog2(NUM_INP) : 1,
   localparam int unsigned PAY_WIDTH   = max3(NUM_INP * CHARGE_WIDTH, RUN_WIDTH,
                                              IDX_WIDTH + CHARGE_WIDTH),
   localparam int unsigned SRC_WIDTH   = OPC_WIDTH + PAY_WIDTH
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      src_valid,
   output logic                                      src_ready,
   input  logic [SRC_WIDTH-1:0]                      src,
   input  logic                                      net_ready,
   output logic                                      net_valid,
   output logic                                      net_rst,
   output logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]      net_inp,
   output logic                                      err,
   output logic                                      busy
);

   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        fifo_pop;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [SRC_WIDTH-1:0]        head;

   opcode_t                     opc;
   logic [PAY_WIDTH-1:0]        pay;
   logic [IDX_WIDTH-1:0]        spk_idx;
   logic [CHARGE_WIDTH-1:0]     spk_charge;
   logic [RUN_WIDTH-1:0]        run_n;

   state_t                      state_q;
   logic [RUN_WIDTH-1:0]        run_cnt_q;
   logic                        settled_q;

   stream_fifo #(
      .WIDTH (SRC_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (src_valid),
      .pop   (fifo_pop),
      .wdata (src),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign src_ready  = !fifo_full;
   assign busy       = (state_q != StIdle) || (fifo_count != '0);
   assign opc        = opcode_t'(head[SRC_WIDTH-1 -: OPC_WIDTH]);
   assign pay        = head[PAY_WIDTH-1:0];
   assign spk_idx    = pay[IDX_WIDTH-1:0];
   assign spk_charge = pay[IDX_WIDTH +: CHARGE_WIDTH];
   assign run_n      = pay[RUN_WIDTH-1:0];

   // A head entry must have been visible for one cycle before it is popped; this
   // fixes the empty-FIFO latency at two edges from push to net_valid/net_rst.
   assign fifo_pop = (state_q == StIdle) && !fifo_empty && settled_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         run_cnt_q <= '0;
         settled_q <= 1'b0;
         net_valid <= 1'b0;
         net_rst   <= 1'b0;
         net_inp   <= '0;
         err       <= 1'b0;
      end else begin
         settled_q <= !fifo_empty;
         net_rst   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (fifo_pop) begin
                  case (opc)
                     OpNom: begin
                        for (int unsigned i = 0; i < NUM_INP; i++) begin
                           net_inp[i] <= pay[PAY_WIDTH-1-i*CHARGE_WIDTH -: CHARGE_WIDTH];
                        end
                        net_valid <= 1'b1;
                        state_q   <= StIssue;
                     end
                     OpSpk: begin
                        if (32'(spk_idx) < NUM_INP) begin
                           for (int unsigned i = 0; i < NUM_INP; i++) begin
                              net_inp[i] <= (32'(spk_idx) == i) ? spk_charge : '0;
                           end
                           net_valid <= 1'b1;
                           state_q   <= StIssue;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     OpRun: begin
                        if (run_n != '0) begin
                           net_inp   <= '0;
                           net_valid <= 1'b1;
                           run_cnt_q <= run_n;
                           state_q   <= StRun;
                        end
                     end
                     OpClr: begin
                        net_rst <= 1'b1;
                        net_inp <= '0;
                        state_q <= StClear;
                     end
                     default: state_q <= StIdle;
                  endcase
               end
            end
            StIssue: begin
               if (net_ready) begin
                  net_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            StRun: begin
               if (net_ready) begin
                  run_cnt_q <= run_cnt_q - 1'b1;
                  if (run_cnt_q == RUN_WIDTH'(1)) begin
                     net_valid <= 1'b0;
                     state_q   <= StIdle;
                  end
               end
            end
            StClear: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_network_stream_source.sv
// Directed bench for network_stream_source: default instance plus a NUM_INP=3
// instance for the out-of-range sparse index case.
module tb_network_stream_source;

   logic              clk = 1'b0;
   logic              rst;
   logic              src_valid;
   logic [33:0]       src;
   logic              net_ready;
   logic              src_ready;
   logic              net_valid;
   logic              net_rst;
   logic [3:0][7:0]   ni;
   logic              err;
   logic              busy;

   logic              src_valid2;
   logic [25:0]       src2;
   logic              src_ready2;
   logic              net_valid2;
   logic              net_rst2;
   logic [2:0][7:0]   ni2;
   logic              err2;
   logic              busy2;

   int                n_vec = 0;
   int                n_err = 0;
   logic [7:0]        hs_q[$];
   int                rst_pulses = 0;
   int                overlap = 0;
   int                n0;
   int                p0;
   logic              seen;
   logic [31:0]       exp_inp;
   logic [23:0]       exp_inp2;

   always #5 clk = ~clk;

   network_stream_source dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src       (src),
      .net_ready (net_ready),
      .net_valid (net_valid),
      .net_rst   (net_rst),
      .net_inp   (ni),
      .err       (err),
      .busy      (busy)
   );

   network_stream_source #(
      .NUM_INP (3)
   ) dut3 (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid2),
      .src_ready (src_ready2),
      .src       (src2),
      .net_ready (1'b0),
      .net_valid (net_valid2),
      .net_rst   (net_rst2),
      .net_inp   (ni2),
      .err       (err2),
      .busy      (busy2)
   );

   always @(posedge clk) begin
      if (!rst && net_valid && net_ready) hs_q.push_back(ni[0]);
      if (net_rst) rst_pulses <= rst_pulses + 1;
      if (net_rst && net_valid) overlap <= overlap + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [33:0] cmd);
      src       = cmd;
      src_valid = 1'b1;
      tick();
      src_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; src_valid = 1'b0; src = '0; net_ready = 1'b0;
      src_valid2 = 1'b0; src2 = '0;
      tick();
      check("rst_src_ready", 64'(src_ready), 64'd1);
      tick();
      rst = 1'b0;
      check("rst_net_valid", 64'(net_valid), 64'd0);
      check("rst_net_rst", 64'(net_rst), 64'd0);
      check("rst_net_inp", 64'(ni), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // NOM {5,-3,0,127} with net_ready held low
      exp_inp = {8'h7F, 8'h00, 8'hFD, 8'h05};
      push({2'd0, 32'h05FD007F});
      check("nom_t0_valid", 64'(net_valid), 64'd0);
      check("nom_t0_busy", 64'(busy), 64'd1);
      tick();
      check("nom_t1_valid", 64'(net_valid), 64'd0);
      tick();
      check("nom_t2_valid", 64'(net_valid), 64'd1);
      check("nom_t2_inp", 64'(ni), 64'(exp_inp));
      for (int i = 0; i < 3; i++) begin
         tick();
         check("nom_hold_valid", 64'(net_valid), 64'd1);
         check("nom_hold_inp", 64'(ni), 64'(exp_inp));
      end
      n0 = hs_q.size();
      net_ready = 1'b1;
      tick();
      net_ready = 1'b0;
      check("nom_hs_valid", 64'(net_valid), 64'd0);
      check("nom_hs_count", 64'(hs_q.size() - n0), 64'd1);
      check("nom_hs_data", 64'(hs_q[hs_q.size()-1]), 64'h05);
      check("nom_busy_done", 64'(busy), 64'd0);

      // RUN 3 with net_ready high
      net_ready = 1'b1;
      n0 = hs_q.size();
      push({2'd2, 32'd3});
      tick();
      tick();
      check("run3_valid", 64'(net_valid), 64'd1);
      check("run3_inp", 64'(ni), 64'd0);
      repeat (3) tick();
      check("run3_end_valid", 64'(net_valid), 64'd0);
      check("run3_hs_count", 64'(hs_q.size() - n0), 64'd3);
      repeat (3) tick();
      check("run3_no_extra", 64'(hs_q.size() - n0), 64'd3);
      net_ready = 1'b0;

      // RUN 0 is dropped
      push({2'd2, 32'd0});
      seen = 1'b0;
      repeat (4) begin
         tick();
         seen = seen | net_valid;
      end
      check("run0_no_valid", 64'(seen), 64'd0);
      check("run0_busy", 64'(busy), 64'd0);

      // CLR: single net_rst pulse at t+2
      p0 = rst_pulses;
      push({2'd1, 32'd0});
      check("clr_t0_rst", 64'(net_rst), 64'd0);
      tick();
      check("clr_t1_rst", 64'(net_rst), 64'd0);
      tick();
      check("clr_t2_rst", 64'(net_rst), 64'd1);
      check("clr_t2_valid", 64'(net_valid), 64'd0);
      check("clr_t2_inp", 64'(ni), 64'd0);
      tick();
      check("clr_t3_rst", 64'(net_rst), 64'd0);
      check("clr_t3_valid", 64'(net_valid), 64'd0);
      tick();
      check("clr_pulses", 64'(rst_pulses - p0), 64'd1);
      check("clr_busy", 64'(busy), 64'd0);

      // SPK idx 2 charge -7
      exp_inp = {8'h00, 8'hF9, 8'h00, 8'h00};
      push({2'd3, 32'h000003E6});
      tick();
      tick();
      check("spk_valid", 64'(net_valid), 64'd1);
      check("spk_inp", 64'(ni), 64'(exp_inp));
      check("spk_err", 64'(err), 64'd0);
      net_ready = 1'b1;
      tick();
      net_ready = 1'b0;
      check("spk_hs_valid", 64'(net_valid), 64'd0);

      // Back-pressure: six NOM pushes against a stalled network
      n0 = hs_q.size();
      for (int k = 1; k <= 5; k++) begin
         check("fill_ready", 64'(src_ready), 64'd1);
         src       = {2'd0, 8'(k), 24'h0};
         src_valid = 1'b1;
         tick();
      end
      src = {2'd0, 8'd6, 24'h0};
      check("full_ready_low", 64'(src_ready), 64'd0);
      check("full_first_valid", 64'(net_valid), 64'd1);
      check("full_first_data", 64'(ni[0]), 64'd1);
      tick();
      check("full_ready_held", 64'(src_ready), 64'd0);
      net_ready = 1'b1;
      tick();
      net_ready = 1'b0;
      check("full_after_hs_valid", 64'(net_valid), 64'd0);
      check("full_after_hs_ready", 64'(src_ready), 64'd0);
      tick();
      check("full_pop_ready", 64'(src_ready), 64'd1);
      check("full_second_valid", 64'(net_valid), 64'd1);
      check("full_second_data", 64'(ni[0]), 64'd2);
      tick();
      src_valid = 1'b0;
      check("full_sixth_taken", 64'(src_ready), 64'd0);
      net_ready = 1'b1;
      for (int i = 0; i < 40 && busy; i++) tick();
      net_ready = 1'b0;
      check("drain_busy", 64'(busy), 64'd0);
      check("drain_hs_count", 64'(hs_q.size() - n0), 64'd6);
      for (int j = 0; j < 6; j++) begin
         check("drain_order", 64'(hs_q[n0+j]), 64'(j + 1));
      end

      // RUN 10 aborted by reset after four handshakes, with a NOM queued behind
      net_ready = 1'b1;
      n0 = hs_q.size();
      push({2'd2, 32'd10});
      push({2'd0, 32'hAA000000});
      for (int i = 0; i < 20 && (hs_q.size() - n0) < 4; i++) tick();
      check("abort_pre_hs", 64'(hs_q.size() - n0), 64'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_valid", 64'(net_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready", 64'(src_ready), 64'd1);
      check("abort_hs", 64'(hs_q.size() - n0), 64'd4);
      repeat (5) tick();
      check("abort_no_more_hs", 64'(hs_q.size() - n0), 64'd4);
      check("abort_still_idle", 64'(net_valid), 64'd0);
      net_ready = 1'b0;

      // NUM_INP=3 instance: index 3 is out of range
      src2 = {2'd3, 24'h000047};
      src_valid2 = 1'b1;
      tick();
      src_valid2 = 1'b0;
      tick();
      check("oor_t1_err", 64'(err2), 64'd0);
      tick();
      check("oor_err", 64'(err2), 64'd1);
      check("oor_valid", 64'(net_valid2), 64'd0);
      check("oor_busy", 64'(busy2), 64'd0);
      repeat (3) tick();
      check("oor_err_sticky", 64'(err2), 64'd1);
      exp_inp2 = {8'h00, 8'h04, 8'h00};
      src2 = {2'd3, 24'h000011};
      src_valid2 = 1'b1;
      tick();
      src_valid2 = 1'b0;
      tick();
      tick();
      check("n3_spk_valid", 64'(net_valid2), 64'd1);
      check("n3_spk_inp", 64'(ni2), 64'(exp_inp2));
      check("n3_err_kept", 64'(err2), 64'd1);
      check("n3_rst_low", 64'(net_rst2), 64'd0);
      check("n3_ready", 64'(src_ready2), 64'd1);

      check("no_rst_valid_overlap", 64'(overlap), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
